// File: rtl/risa_cmd_sequencer_pkg.sv
// Shared types and constants for the RISA command sequencer.
// Command port layout, target codes, unit idle codes and FSM encodings.
package risa_cmd_sequencer_pkg;

  localparam int STATE_WIDTH    = 4;
  localparam int SEQ_FIFO_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [7:0]  command;
    logic [31:0] data0;
    logic [31:0] data1;
  } cmd_port_t;

  localparam logic [2:0] SEQ_TGT_QUANT   = 3'd0;
  localparam logic [2:0] SEQ_TGT_WEIGHT  = 3'd1;
  localparam logic [2:0] SEQ_TGT_REQUANT = 3'd2;
  localparam logic [2:0] SEQ_TGT_BARRIER = 3'd3;

  localparam logic [STATE_WIDTH-1:0] BUFFER_QUANT_IDLE  = '0;
  localparam logic [STATE_WIDTH-1:0] BUFFER_WEIGHT_IDLE = '0;
  localparam logic [STATE_WIDTH-1:0] REQUANT_IDLE       = '0;

  typedef enum logic [STATE_WIDTH-1:0] {
    SEQ_IDLE = STATE_WIDTH'(0),
    SEQ_WAIT = STATE_WIDTH'(1),
    SEQ_HOLD = STATE_WIDTH'(2)
  } seq_state_e;

endpackage

// File: rtl/risa_cmd_fifo.sv
// Synchronous FIFO of command words.
// Push is ignored when full, pop is ignored when empty.
module risa_cmd_fifo
  import risa_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = SEQ_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  cmd_port_t                data_i,
  input  logic                     pop_i,
  output cmd_port_t                data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_port_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; wraps naturally for power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/risa_cmd_sequencer.sv
// In-order command dispatcher to quant, weight and requant units.
// One issue at a time; a guard window follows each issue or barrier.
module risa_cmd_sequencer
  import risa_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = SEQ_FIFO_DEPTH,
  parameter int START_GUARD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  cmd_port_t              cmd_in,
  output logic                   cmd_in_ready,
  input  logic [STATE_WIDTH-1:0] quant_state,
  input  logic [STATE_WIDTH-1:0] weight_state,
  input  logic [STATE_WIDTH-1:0] requant_state,
  output cmd_port_t              quant_cmd,
  output cmd_port_t              weight_cmd,
  output cmd_port_t              requant_cmd,
  output logic                   barrier_done,
  output logic [15:0]            barrier_tag,
  output logic                   err_bad_target,
  output logic [7:0]             err_count,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(START_GUARD + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(START_GUARD - 1);

  seq_state_e    state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  cmd_port_t     quant_q, quant_d;
  cmd_port_t     weight_q, weight_d;
  cmd_port_t     requant_q, requant_d;
  logic          bdone_q, bdone_d;
  logic [15:0]   tag_q, tag_d;
  logic          err_q, err_d;
  logic [7:0]    errcnt_q, errcnt_d;

  cmd_port_t     head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          push, pop;
  logic [2:0]    tgt;
  logic          q_idle, w_idle, r_idle;

  assign push   = cmd_in.valid && !fifo_full;
  assign tgt    = head.command[7:5];
  assign q_idle = (quant_state == BUFFER_QUANT_IDLE);
  assign w_idle = (weight_state == BUFFER_WEIGHT_IDLE);
  assign r_idle = (requant_state == REQUANT_IDLE);

  risa_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_in.valid),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign cmd_in_ready   = !fifo_full;
  assign busy           = !fifo_empty || (state_q != SEQ_IDLE);
  assign quant_cmd      = quant_q;
  assign weight_cmd     = weight_q;
  assign requant_cmd    = requant_q;
  assign barrier_done   = bdone_q;
  assign barrier_tag    = tag_q;
  assign err_bad_target = err_q;
  assign err_count      = errcnt_q;

  // State, guard and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      guard_q   <= '0;
      quant_q   <= '0;
      weight_q  <= '0;
      requant_q <= '0;
      bdone_q   <= 1'b0;
      tag_q     <= '0;
      err_q     <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      quant_q   <= quant_d;
      weight_q  <= weight_d;
      requant_q <= requant_d;
      bdone_q   <= bdone_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Head decode, dispatch decision and next state.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    pop       = 1'b0;
    quant_d   = '0;
    weight_d  = '0;
    requant_d = '0;
    bdone_d   = 1'b0;
    tag_d     = tag_q;
    err_d     = 1'b0;
    errcnt_d  = errcnt_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (push || !fifo_empty) state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (fifo_empty) begin
          if (!push) state_d = SEQ_IDLE;
        end else begin
          case (tgt)
            SEQ_TGT_QUANT: begin
              if (q_idle) begin
                pop           = 1'b1;
                quant_d       = head;
                quant_d.valid = 1'b1;
                state_d       = SEQ_HOLD;
                guard_d       = GUARD_LOAD;
              end
            end
            SEQ_TGT_WEIGHT: begin
              if (w_idle) begin
                pop            = 1'b1;
                weight_d       = head;
                weight_d.valid = 1'b1;
                state_d        = SEQ_HOLD;
                guard_d        = GUARD_LOAD;
              end
            end
            SEQ_TGT_REQUANT: begin
              if (r_idle) begin
                pop             = 1'b1;
                requant_d       = head;
                requant_d.valid = 1'b1;
                state_d         = SEQ_HOLD;
                guard_d         = GUARD_LOAD;
              end
            end
            SEQ_TGT_BARRIER: begin
              if (q_idle && w_idle && r_idle) begin
                pop     = 1'b1;
                bdone_d = 1'b1;
                tag_d   = head.data0[15:0];
                state_d = SEQ_HOLD;
                guard_d = GUARD_LOAD;
              end
            end
            default: begin
              pop   = 1'b1;
              err_d = 1'b1;
              if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
              if (fifo_cnt == CW'(1) && !push) state_d = SEQ_IDLE;
            end
          endcase
        end
      end
      SEQ_HOLD: begin
        if (guard_q == '0) begin
          state_d = (push || !fifo_empty) ? SEQ_WAIT : SEQ_IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risa_cmd_sequencer.sv
// Bench for risa_cmd_sequencer: directed timing scenarios plus a random
// stream checked for order, content, idle-eligibility and issue spacing.
module tb_risa_cmd_sequencer;
  import risa_cmd_sequencer_pkg::*;

  localparam int DEPTH = 8;
  localparam int GUARD = 2;
  localparam int HMAX  = 8192;

  logic                   clk = 1'b0;
  logic                   rst;
  cmd_port_t              cmd_in;
  logic                   cmd_in_ready;
  logic [STATE_WIDTH-1:0] quant_state;
  logic [STATE_WIDTH-1:0] weight_state;
  logic [STATE_WIDTH-1:0] requant_state;
  cmd_port_t              quant_cmd;
  cmd_port_t              weight_cmd;
  cmd_port_t              requant_cmd;
  logic                   barrier_done;
  logic [15:0]            barrier_tag;
  logic                   err_bad_target;
  logic [7:0]             err_count;
  logic                   busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  risa_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .START_GUARD (GUARD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_in         (cmd_in),
    .cmd_in_ready   (cmd_in_ready),
    .quant_state    (quant_state),
    .weight_state   (weight_state),
    .requant_state  (requant_state),
    .quant_cmd      (quant_cmd),
    .weight_cmd     (weight_cmd),
    .requant_cmd    (requant_cmd),
    .barrier_done   (barrier_done),
    .barrier_tag    (barrier_tag),
    .err_bad_target (err_bad_target),
    .err_count      (err_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 quant, 1 weight, 2 requant, 3 barrier, 4 dropped
  typedef struct {
    int          cyc;
    int          kind;
    cmd_port_t   c;
    logic [15:0] tag;
  } ev_t;

  ev_t evq[$];
  logic [STATE_WIDTH-1:0] qh [HMAX];
  logic [STATE_WIDTH-1:0] wh [HMAX];
  logic [STATE_WIDTH-1:0] rh [HMAX];

  function automatic ev_t mk_ev(int k, cmd_port_t c, logic [15:0] t);
    ev_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.c    = c;
    e.tag  = t;
    return e;
  endfunction

  function automatic int kind_of(cmd_port_t c);
    int k;
    k = int'(c.command[7:5]);
    return (k < 4) ? k : 4;
  endfunction

  // Observe outputs mid-cycle and log every output event.
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      qh[cyc] = quant_state;
      wh[cyc] = weight_state;
      rh[cyc] = requant_state;
    end
    if (!rst) begin
      if (quant_cmd.valid)   evq.push_back(mk_ev(0, quant_cmd, 16'h0));
      if (weight_cmd.valid)  evq.push_back(mk_ev(1, weight_cmd, 16'h0));
      if (requant_cmd.valid) evq.push_back(mk_ev(2, requant_cmd, 16'h0));
      if (barrier_done)      evq.push_back(mk_ev(3, '0, barrier_tag));
      if (err_bad_target)    evq.push_back(mk_ev(4, '0, 16'h0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] c, input logic [31:0] d0,
                          input logic [31:0] d1, output int t);
    int k;
    cmd_in = '{valid: 1'b1, command: c, data0: d0, data1: d1};
    k = 0;
    while (!cmd_in_ready && k < 100) begin
      step();
      k++;
    end
    n_checks++;
    if (cmd_in_ready !== 1'b1)
      $display("FAIL push_ready: got %b want 1", cmd_in_ready);
    else n_pass++;
    t = cyc;
    step();
    cmd_in.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_in = '0;
    quant_state = '0;
    weight_state = '0;
    requant_state = '0;
    repeat (3) step();
    n_checks++;
    if ({quant_cmd.valid, weight_cmd.valid, requant_cmd.valid} !== 3'b000)
      $display("FAIL reset_valids: got %b want 000",
               {quant_cmd.valid, weight_cmd.valid, requant_cmd.valid});
    else n_pass++;
    n_checks++;
    if ({barrier_done, err_bad_target, busy} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000",
               {barrier_done, err_bad_target, busy});
    else n_pass++;
    n_checks++;
    if (barrier_tag !== 16'h0 || err_count !== 8'h0)
      $display("FAIL reset_regs: tag %h cnt %h want 0 0", barrier_tag, err_count);
    else n_pass++;
    n_checks++;
    if (cmd_in_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", cmd_in_ready);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int t;
    evq.delete();
    push_one(8'h02, 32'd5, 32'h1234, t);
    repeat (8) step();
    n_checks++;
    if (evq.size() != 1) begin
      $display("FAIL single_count: got %0d events want 1", evq.size());
    end else begin
      n_pass++;
      n_checks++;
      if (evq[0].kind != 0 || evq[0].cyc != t + 2)
        $display("FAIL single_timing: got kind %0d cyc %0d want 0 %0d",
                 evq[0].kind, evq[0].cyc, t + 2);
      else n_pass++;
      n_checks++;
      if (evq[0].c.data0 !== 32'd5 || evq[0].c.command !== 8'h02 ||
          evq[0].c.data1 !== 32'h1234)
        $display("FAIL single_data: got %h/%h/%h want 02/5/1234",
                 evq[0].c.command, evq[0].c.data0, evq[0].c.data1);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_busy_weight();
    int t;
    int u;
    weight_state = 4'd1;
    evq.delete();
    push_one(8'h22, 32'hA5, 32'h0, t);
    repeat (6) step();
    n_checks++;
    if (evq.size() != 0)
      $display("FAIL weight_stall: got %0d events want 0", evq.size());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL weight_busy: got %b want 1", busy);
    else n_pass++;
    weight_state = '0;
    u = cyc;
    repeat (6) step();
    n_checks++;
    if (evq.size() != 1 || evq[0].kind != 1 || evq[0].cyc != u + 1 ||
        evq[0].c.command !== 8'h22)
      $display("FAIL weight_release: got %0d events first cyc %0d want 1 at %0d",
               evq.size(), (evq.size() > 0) ? evq[0].cyc : -1, u + 1);
    else n_pass++;
  endtask

  task automatic test_barrier();
    int t;
    int t2;
    int u;
    evq.delete();
    push_one(8'h03, 32'd9, 32'h0, t);
    push_one(8'h60, 32'hBEEF, 32'h0, t2);
    quant_state = 4'd1;
    repeat (10) step();
    quant_state = '0;
    u = cyc;
    repeat (6) step();
    n_checks++;
    if (evq.size() != 2) begin
      $display("FAIL barrier_count: got %0d events want 2", evq.size());
    end else begin
      n_pass++;
      n_checks++;
      if (evq[0].kind != 0 || evq[0].cyc != t + 2)
        $display("FAIL barrier_first: got kind %0d cyc %0d want 0 %0d",
                 evq[0].kind, evq[0].cyc, t + 2);
      else n_pass++;
      n_checks++;
      if (evq[1].kind != 3 || evq[1].cyc != u + 1 || evq[1].tag !== 16'hBEEF)
        $display("FAIL barrier_done: got kind %0d cyc %0d tag %h want 3 %0d beef",
                 evq[1].kind, evq[1].cyc, evq[1].tag, u + 1);
      else n_pass++;
    end
    n_checks++;
    if (barrier_tag !== 16'hBEEF)
      $display("FAIL barrier_tag_hold: got %h want beef", barrier_tag);
    else n_pass++;
  endtask

  task automatic test_fill();
    int u;
    requant_state = 4'd3;
    evq.delete();
    for (int i = 0; i < 9; i++) begin
      cmd_in = '{valid: 1'b1, command: 8'h40 | 8'(i),
                 data0: 32'(i), data1: 32'(i * 3)};
      n_checks++;
      if (cmd_in_ready !== (i < DEPTH))
        $display("FAIL fill_ready_%0d: got %b want %b", i, cmd_in_ready, i < DEPTH);
      else n_pass++;
      step();
    end
    cmd_in.valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (cmd_in_ready !== 1'b0 || evq.size() != 0)
      $display("FAIL fill_full: ready %b events %0d want 0 0",
               cmd_in_ready, evq.size());
    else n_pass++;
    requant_state = '0;
    u = cyc;
    repeat (35) step();
    n_checks++;
    if (evq.size() != DEPTH) begin
      $display("FAIL fill_drain: got %0d events want %0d", evq.size(), DEPTH);
    end else begin
      n_pass++;
      for (int k = 0; k < DEPTH; k++) begin
        n_checks++;
        if (evq[k].kind != 2 || evq[k].cyc != u + 1 + 3 * k ||
            evq[k].c.data0 !== 32'(k))
          $display("FAIL fill_issue_%0d: got kind %0d cyc %0d d0 %0d want 2 %0d %0d",
                   k, evq[k].kind, evq[k].cyc, evq[k].c.data0, u + 1 + 3 * k, k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    int t;
    int t2;
    evq.delete();
    push_one(8'hA0, 32'h0, 32'h0, t);
    push_one(8'h02, 32'd7, 32'h0, t2);
    repeat (8) step();
    n_checks++;
    if (evq.size() != 2) begin
      $display("FAIL illegal_count: got %0d events want 2", evq.size());
    end else begin
      n_pass++;
      n_checks++;
      if (evq[0].kind != 4 || evq[0].cyc != t + 2)
        $display("FAIL illegal_pulse: got kind %0d cyc %0d want 4 %0d",
                 evq[0].kind, evq[0].cyc, t + 2);
      else n_pass++;
      n_checks++;
      if (evq[1].kind != 0 || evq[1].cyc != t + 3 || evq[1].c.data0 !== 32'd7)
        $display("FAIL illegal_follow: got kind %0d cyc %0d want 0 %0d",
                 evq[1].kind, evq[1].cyc, t + 3);
      else n_pass++;
    end
    n_checks++;
    if (err_count !== 8'd1)
      $display("FAIL illegal_errcnt: got %0d want 1", err_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    requant_state = 4'd2;
    evq.delete();
    for (int i = 0; i < 4; i++) push_one(8'h41, 32'(i), 32'h0, t);
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cmd_in_ready !== 1'b1)
      $display("FAIL mid_reset_async: busy %b ready %b want 0 1", busy, cmd_in_ready);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'h0 || barrier_tag !== 16'h0 ||
        {quant_cmd.valid, weight_cmd.valid, requant_cmd.valid} !== 3'b000)
      $display("FAIL mid_reset_regs: cnt %h tag %h want 0 0", err_count, barrier_tag);
    else n_pass++;
    step();
    rst = 1'b0;
    requant_state = '0;
    repeat (20) step();
    n_checks++;
    if (evq.size() != 0 || busy !== 1'b0)
      $display("FAIL mid_reset_discard: events %0d busy %b want 0 0",
               evq.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    cmd_port_t expq[$];
    int        n_ill;
    int        k;
    int        r;
    logic [2:0] tg;
    n_ill = 0;
    evq.delete();
    k = 0;
    while (expq.size() < 60 && k < 1500) begin
      quant_state   = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : '0;
      weight_state  = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : '0;
      requant_state = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 11);
        if (r < 9)       tg = 3'(r % 3);
        else if (r == 9) tg = 3'd3;
        else             tg = 3'(4 + $urandom_range(0, 3));
        cmd_in = '{valid: 1'b1,
                   command: {tg, 5'($urandom_range(0, 31))},
                   data0: $urandom, data1: $urandom};
      end else begin
        cmd_in.valid = 1'b0;
      end
      if (cmd_in.valid && cmd_in_ready) begin
        expq.push_back(cmd_in);
        if (kind_of(cmd_in) == 4) n_ill++;
      end
      step();
      k++;
    end
    cmd_in.valid = 1'b0;
    quant_state = '0;
    weight_state = '0;
    requant_state = '0;
    k = 0;
    while (evq.size() < expq.size() && k < 2000) begin
      step();
      k++;
    end
    repeat (5) step();
    n_checks++;
    if (evq.size() != expq.size())
      $display("FAIL rand_count: got %0d events want %0d", evq.size(), expq.size());
    else n_pass++;
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      int ek;
      int c;
      ek = kind_of(expq[i]);
      c = evq[i].cyc - 1;
      n_checks++;
      if (evq[i].kind != ek)
        $display("FAIL rand_kind_%0d: got %0d want %0d", i, evq[i].kind, ek);
      else n_pass++;
      if (ek < 3) begin
        n_checks++;
        if (evq[i].c !== expq[i])
          $display("FAIL rand_data_%0d: got %h want %h", i, evq[i].c, expq[i]);
        else n_pass++;
        n_checks++;
        if ((ek == 0 && qh[c] != '0) || (ek == 1 && wh[c] != '0) ||
            (ek == 2 && rh[c] != '0))
          $display("FAIL rand_idle_%0d: target %0d busy at cycle %0d", i, ek, c);
        else n_pass++;
      end else if (ek == 3) begin
        n_checks++;
        if (evq[i].tag !== expq[i].data0[15:0] ||
            qh[c] != '0 || wh[c] != '0 || rh[c] != '0)
          $display("FAIL rand_barrier_%0d: got tag %h want %h", i,
                   evq[i].tag, expq[i].data0[15:0]);
        else n_pass++;
      end
      if (i > 0 && evq[i - 1].kind < 4) begin
        n_checks++;
        if (evq[i].cyc - evq[i - 1].cyc < GUARD + 1)
          $display("FAIL rand_spacing_%0d: got gap %0d want >= %0d", i,
                   evq[i].cyc - evq[i - 1].cyc, GUARD + 1);
        else n_pass++;
      end
    end
    n_checks++;
    if (err_count !== 8'(n_ill) || busy !== 1'b0)
      $display("FAIL rand_final: errcnt %0d busy %b want %0d 0",
               err_count, busy, n_ill);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_weight();
    test_barrier();
    test_fill();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
